// File: rtl/qspi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_flash_reader
//  Description : QSPI flash read controller. Issues Fast Read Quad Output
//                (0x6B) at a 24-bit address, then streams DATA_WIDTH_BYTES
//                words on request into the downstream prefetch buffer.
//                SPI clock runs at clk/2 (mode 0) and is held low when stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_flash_reader #(
    parameter int DATA_WIDTH_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start_read,
    input  logic                          stop_read,
    input  logic                          continue_read,
    input  logic [23:0]                   addr_in,
    output logic [DATA_WIDTH_BYTES*8-1:0] data_out,
    output logic                          busy,
    output logic                          spi_select,
    output logic                          spi_clk_out,
    output logic [3:0]                    spi_data_out,
    output logic [3:0]                    spi_data_oe,
    input  logic [3:0]                    spi_data_in
);

    localparam int         c_WORD_W    = DATA_WIDTH_BYTES * 8;
    localparam int         c_POS_W     = (c_WORD_W > 1) ? $clog2(c_WORD_W) : 1;
    localparam logic [7:0] c_CMD_QREAD = 8'h6B;
    localparam logic [7:0] c_CMD_LAST  = 8'd7;
    localparam logic [7:0] c_ADDR_LAST = 8'd23;
    localparam logic [7:0] c_DUM_LAST  = 8'd7;
    localparam logic [7:0] c_DATA_LAST = 8'(2 * DATA_WIDTH_BYTES - 1);
    localparam logic [7:0] c_DSL_LAST  = 8'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_STALL = 3'd5,
        ST_DESEL = 3'd6
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;      // bit / nibble / cycle index within the state
    logic [31:0]           r_tx;       // command + address shifted out MSB first
    logic [c_WORD_W-1:0]   r_rx;       // word under assembly, never visible outside

    state_t                w_state_nxt;
    logic [7:0]            w_cnt_nxt;
    logic [31:0]           w_tx_nxt;
    logic [c_WORD_W-1:0]   w_rx_nxt;
    logic [c_WORD_W-1:0]   w_word_nxt;
    logic                  w_busy_nxt;
    logic                  w_sel_nxt;
    logic                  w_sclk_nxt;
    logic [3:0]            w_sd_nxt;
    logic [3:0]            w_oe_nxt;
    logic [c_POS_W-1:0]    w_nib_pos;

    // Nibble n lands in byte n/2; even nibbles are the high half of that byte.
    assign w_nib_pos = c_POS_W'({r_cnt[7:1], ~r_cnt[0], 2'b00});

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_word_nxt  = data_out;
        w_busy_nxt  = busy;
        w_sel_nxt   = spi_select;
        w_sclk_nxt  = spi_clk_out;
        w_sd_nxt    = spi_data_out;
        w_oe_nxt    = spi_data_oe;

        if (start_read) begin
            // New read always wins; an active transaction is torn down first.
            w_tx_nxt   = {c_CMD_QREAD, addr_in};
            w_cnt_nxt  = '0;
            w_busy_nxt = 1'b1;
            w_sclk_nxt = 1'b0;
            if (r_state == ST_IDLE) begin
                w_state_nxt = ST_CMD;
                w_sel_nxt   = 1'b0;
                w_sd_nxt    = {3'b000, c_CMD_QREAD[7]};
                w_oe_nxt    = 4'b0001;
            end else begin
                w_state_nxt = ST_DESEL;
                w_sel_nxt   = 1'b1;
                w_sd_nxt    = 4'b0000;
                w_oe_nxt    = 4'b0000;
            end
        end else if (stop_read && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_sel_nxt   = 1'b1;
            w_sclk_nxt  = 1'b0;
            w_sd_nxt    = 4'b0000;
            w_oe_nxt    = 4'b0000;
        end else begin
            case (r_state)
                ST_DESEL: begin
                    if (r_cnt == c_DSL_LAST) begin
                        w_state_nxt = ST_CMD;
                        w_cnt_nxt   = '0;
                        w_sel_nxt   = 1'b0;
                        w_sd_nxt    = {3'b000, r_tx[31]};
                        w_oe_nxt    = 4'b0001;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    if (!spi_clk_out) begin
                        // Low phase ends: raise SCK, hold everything else.
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // High phase ends: sample, then set up the next low phase.
                        w_sclk_nxt = 1'b0;
                        w_cnt_nxt  = r_cnt + 8'd1;
                        case (r_state)
                            ST_CMD: begin
                                w_tx_nxt = {r_tx[30:0], 1'b0};
                                w_sd_nxt = {3'b000, r_tx[30]};
                                if (r_cnt == c_CMD_LAST) begin
                                    w_state_nxt = ST_ADDR;
                                    w_cnt_nxt   = '0;
                                end
                            end
                            ST_ADDR: begin
                                w_tx_nxt = {r_tx[30:0], 1'b0};
                                w_sd_nxt = {3'b000, r_tx[30]};
                                if (r_cnt == c_ADDR_LAST) begin
                                    w_state_nxt = ST_DUMMY;
                                    w_cnt_nxt   = '0;
                                    w_sd_nxt    = 4'b0000;
                                    w_oe_nxt    = 4'b0000;
                                end
                            end
                            ST_DUMMY: begin
                                if (r_cnt == c_DUM_LAST) begin
                                    w_state_nxt = ST_DATA;
                                    w_cnt_nxt   = '0;
                                end
                            end
                            ST_DATA: begin
                                w_rx_nxt[w_nib_pos +: 4] = spi_data_in;
                                if (r_cnt == c_DATA_LAST) begin
                                    w_state_nxt = ST_STALL;
                                    w_cnt_nxt   = '0;
                                    w_busy_nxt  = 1'b0;
                                    w_word_nxt  = w_rx_nxt;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_STALL: begin
                    // Flash keeps CS low and auto-increments, so just clock more data.
                    if (continue_read) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            data_out     <= '0;
            busy         <= 1'b0;
            spi_select   <= 1'b1;
            spi_clk_out  <= 1'b0;
            spi_data_out <= 4'b0000;
            spi_data_oe  <= 4'b0000;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_tx         <= w_tx_nxt;
            r_rx         <= w_rx_nxt;
            data_out     <= w_word_nxt;
            busy         <= w_busy_nxt;
            spi_select   <= w_sel_nxt;
            spi_clk_out  <= w_sclk_nxt;
            spi_data_out <= w_sd_nxt;
            spi_data_oe  <= w_oe_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_flash_reader
//  Description : Self-checking bench for qspi_flash_reader with a small
//                QSPI flash model and a word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_flash_reader;

    logic        clk;
    logic        rstn;
    logic        start_read;
    logic        stop_read;
    logic        continue_read;
    logic [23:0] addr_in;
    logic [31:0] data_out;
    logic        busy;
    logic        spi_select;
    logic        spi_clk_out;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic [3:0]  spi_data_in;

    qspi_flash_reader #(.DATA_WIDTH_BYTES(4)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_read    (start_read),
        .stop_read     (stop_read),
        .continue_read (continue_read),
        .addr_in       (addr_in),
        .data_out      (data_out),
        .busy          (busy),
        .spi_select    (spi_select),
        .spi_clk_out   (spi_clk_out),
        .spi_data_out  (spi_data_out),
        .spi_data_oe   (spi_data_oe),
        .spi_data_in   (spi_data_in)
    );

    typedef struct {
        logic [31:0] word;
        int          due;
    } exp_t;

    exp_t        exp_word[$];
    logic [31:0] exp_cmd[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] held     = 32'h0;
    logic        prev_busy = 1'b0;
    int          m_n      = 0;
    logic [31:0] m_sh     = 32'h0;
    logic [23:0] m_addr   = 24'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        case (a)
            24'h123456: return 8'h12;
            24'h123457: return 8'h34;
            24'h123458: return 8'h56;
            24'h123459: return 8'h78;
            24'h12345A: return 8'hAB;
            24'h12345B: return 8'hCD;
            24'h12345C: return 8'hEF;
            24'h12345D: return 8'h12;
            24'h000100: return 8'hC3;
            24'h000101: return 8'h5A;
            24'h000102: return 8'h96;
            24'h000103: return 8'h0F;
            default:    return 8'hFF;
        endcase
    endfunction

    // Flash model: counts SPI clocks per CS-low session, captures cmd/addr, drives data.
    always @(negedge clk) begin
        logic [7:0] b;
        int         idx;
        if (spi_select !== 1'b0) begin
            m_n = 0;
        end else if (spi_clk_out === 1'b1) begin
            if (m_n < 32) begin
                chk("oe_cmd_addr", spi_data_oe, 4'b0001);
                chk("sd_upper_zero", spi_data_out[3:1], 3'b000);
                m_sh = {m_sh[30:0], spi_data_out[0]};
                if (m_n == 31) begin
                    m_addr = m_sh[23:0];
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd: got %0h expected none", m_sh);
                    end else begin
                        chk("cmd_addr_bits", m_sh, exp_cmd.pop_front());
                    end
                end
            end else begin
                chk("oe_dummy_data", spi_data_oe, 4'b0000);
                if (m_n >= 40) begin
                    idx = m_n - 40;
                    b = mem_rd(m_addr + 24'(idx / 2));
                    spi_data_in = (idx % 2 == 0) ? b[7:4] : b[3:0];
                end
            end
            m_n++;
        end
    end

    // Scoreboard monitor: a completed word is a busy fall with CS still asserted.
    always @(negedge clk) begin
        exp_t e;
        if (prev_busy && !busy && spi_select === 1'b0) begin
            if (exp_word.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %0h expected none", data_out);
            end else begin
                e = exp_word.pop_front();
                chk("word_data", data_out, e.word);
                chk("word_latency", cyc, e.due);
                held = e.word;
            end
        end else if (busy === 1'b1) begin
            chk("data_held_while_busy", data_out, held);
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_words(input int limit);
        int n = 0;
        while (exp_word.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_word.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL word_timeout: got %0d pending expected 0", exp_word.size());
            exp_word.delete();
        end
    endtask

    task automatic expect_quiet(input string name, input int ncyc, input logic want_sel);
        logic act = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || spi_clk_out !== 1'b0 || spi_select !== want_sel) act = 1'b1;
        end
        chk(name, act, 1'b0);
    endtask

    // Directed stimulus sequence.
    initial begin
        int t0, tc, t4, ts, t5, t6;
        rstn = 1'b0; start_read = 1'b0; stop_read = 1'b0; continue_read = 1'b0;
        addr_in = 24'h0; spi_data_in = 4'hF;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_select", spi_select, 1'b1);
        chk("rst_sclk", spi_clk_out, 1'b0);
        chk("rst_oe", spi_data_oe, 4'b0000);
        chk("rst_sd", spi_data_out, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", data_out, 32'h0);
        tick(); rstn = 1'b1;

        // Read at 0x123456: command, address, dummies, word 0x78563412 at +97.
        tick();
        addr_in = 24'h123456; start_read = 1'b1; t0 = cyc;
        exp_cmd.push_back(32'h6B123456);
        exp_word.push_back('{32'h78563412, t0 + 97});
        tick(); start_read = 1'b0;
        @(negedge clk);
        chk("start_select_low", spi_select, 1'b0);
        chk("start_busy_high", busy, 1'b1);
        wait_words(200);
        chk("select_held_in_stall", spi_select, 1'b0);
        chk("clocks_first_word", m_n, 48);

        // Continue 10 cycles after the word; a second continue while busy is ignored.
        while (cyc < t0 + 107) tick();
        continue_read = 1'b1; tc = cyc;
        exp_word.push_back('{32'h12EFCDAB, tc + 17});
        tick(); continue_read = 1'b0;
        @(negedge clk);
        chk("continue_busy_high", busy, 1'b1);
        while (cyc < tc + 5) tick();
        continue_read = 1'b1;
        tick(); continue_read = 1'b0;
        wait_words(40);
        chk("clocks_second_word", m_n, 56);
        chk("select_after_continue", spi_select, 1'b0);

        // Restart at 0x000100 in the middle of a continued word.
        tick();
        continue_read = 1'b1; t4 = cyc;
        tick(); continue_read = 1'b0;
        while (cyc < t4 + 6) tick();
        addr_in = 24'h000100; start_read = 1'b1; ts = cyc;
        exp_cmd.push_back(32'h6B000100);
        exp_word.push_back('{32'h0F965AC3, ts + 99});
        tick(); start_read = 1'b0;
        @(negedge clk);
        chk("desel1_select", spi_select, 1'b1);
        chk("desel1_busy", busy, 1'b1);
        @(negedge clk);
        chk("desel2_select", spi_select, 1'b1);
        chk("desel2_busy", busy, 1'b1);
        @(negedge clk);
        chk("recmd_select", spi_select, 1'b0);
        wait_words(150);

        // stop_read together with continue_read in STALL: stop wins.
        tick(); tick();
        stop_read = 1'b1; continue_read = 1'b1; t5 = cyc;
        tick(); stop_read = 1'b0; continue_read = 1'b0;
        @(negedge clk);
        chk("stop_select", spi_select, 1'b1);
        chk("stop_busy", busy, 1'b0);
        chk("stop_oe", spi_data_oe, 4'b0000);
        chk("stop_data_kept", data_out, 32'h0F965AC3);
        chk("stop_cycle", cyc, t5 + 1);
        expect_quiet("stop_no_activity", 20, 1'b1);

        // Reset in the middle of the address phase.
        tick();
        addr_in = 24'h00ABCD; start_read = 1'b1; t6 = cyc;
        tick(); start_read = 1'b0;
        while (cyc < t6 + 30) tick();
        rstn = 1'b0;
        tick(); rstn = 1'b1;
        @(negedge clk);
        chk("midrst_select", spi_select, 1'b1);
        chk("midrst_oe", spi_data_oe, 4'b0000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_sclk", spi_clk_out, 1'b0);
        chk("midrst_data", data_out, 32'h0);
        held = 32'h0;
        tick();
        continue_read = 1'b1;
        tick(); continue_read = 1'b0;
        expect_quiet("continue_after_reset_ignored", 20, 1'b1);
        chk("cmd_queue_drained", exp_cmd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute simulation bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
